// File: rtl/keccak_squeeze_ctrl.sv
// rtl/keccak_squeeze_ctrl.sv - Keccak squeeze-phase controller streaming rate words as digest output
module keccak_squeeze_ctrl #(
    parameter int W_ADDR = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cmode,
    input  logic [10:0]       d,
    input  logic              start,
    output logic              st_rd,
    output logic [W_ADDR-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              perm_req,
    input  logic              perm_done,
    output logic [31:0]       dt_o_hash,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              finish_hash,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_OUT,
        S_PERM,
        S_DONE
    } state_t;

    state_t            state;
    logic [5:0]        nwords;
    logic [5:0]        cnt;
    logic [W_ADDR-1:0] rate;
    logic [W_ADDR-1:0] widx;

    logic [5:0]        lk_nwords;
    logic [W_ADDR-1:0] lk_rate;
    logic              unused_d;

    // SHAKE lengths are truncated to whole words; the low five bits of d are dropped.
    assign unused_d = ^d[4:0];

    always_comb begin
        lk_nwords = 6'd0;
        lk_rate   = W_ADDR'(0);
        case (cmode)
            3'd0: begin lk_nwords = 6'd7;     lk_rate = W_ADDR'(36); end
            3'd1: begin lk_nwords = 6'd8;     lk_rate = W_ADDR'(34); end
            3'd2: begin lk_nwords = 6'd12;    lk_rate = W_ADDR'(26); end
            3'd3: begin lk_nwords = 6'd16;    lk_rate = W_ADDR'(18); end
            3'd4: begin lk_nwords = d[10:5];  lk_rate = W_ADDR'(42); end
            3'd5: begin lk_nwords = d[10:5];  lk_rate = W_ADDR'(34); end
            default: begin lk_nwords = 6'd0;  lk_rate = W_ADDR'(0);  end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            nwords      <= 6'd0;
            cnt         <= 6'd0;
            rate        <= W_ADDR'(0);
            widx        <= W_ADDR'(0);
            st_rd       <= 1'b0;
            st_addr     <= W_ADDR'(0);
            perm_req    <= 1'b0;
            dt_o_hash   <= 32'd0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            finish_hash <= 1'b0;
            busy        <= 1'b0;
        end else begin
            st_rd       <= 1'b0;
            finish_hash <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nwords <= lk_nwords;
                        rate   <= lk_rate;
                        cnt    <= 6'd0;
                        widx   <= W_ADDR'(0);
                        busy   <= 1'b1;
                        if (lk_nwords == 6'd0) begin
                            state       <= S_DONE;
                            finish_hash <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            st_rd   <= 1'b1;
                            st_addr <= W_ADDR'(0);
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    dt_o_hash <= st_data;
                    o_valid   <= 1'b1;
                    o_last    <= (cnt == nwords - 6'd1);
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        cnt     <= cnt + 6'd1;
                        widx    <= widx + W_ADDR'(1);
                        if (o_last) begin
                            state       <= S_DONE;
                            finish_hash <= 1'b1;
                        end else if (widx == rate - W_ADDR'(1)) begin
                            // Rate block exhausted: permute before reading further words.
                            state    <= S_PERM;
                            perm_req <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            st_rd   <= 1'b1;
                            st_addr <= widx + W_ADDR'(1);
                        end
                    end
                end
                S_PERM: begin
                    if (perm_done) begin
                        perm_req <= 1'b0;
                        widx     <= W_ADDR'(0);
                        state    <= S_FETCH;
                        st_rd    <= 1'b1;
                        st_addr  <= W_ADDR'(0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// tb/tb_keccak_squeeze_ctrl.sv - table-driven scoreboard bench for keccak_squeeze_ctrl
module tb_keccak_squeeze_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cmode;
    logic [10:0] d;
    logic        start;
    logic        st_rd;
    logic [5:0]  st_addr;
    logic [31:0] st_data;
    logic        perm_req;
    logic        perm_done;
    logic [31:0] dt_o_hash;
    logic        o_valid;
    logic        o_ready;
    logic        o_last;
    logic        finish_hash;
    logic        busy;

    keccak_squeeze_ctrl #(.W_ADDR(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmode      (cmode),
        .d          (d),
        .start      (start),
        .st_rd      (st_rd),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .perm_req   (perm_req),
        .perm_done  (perm_done),
        .dt_o_hash  (dt_o_hash),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_last     (o_last),
        .finish_hash(finish_hash),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cmode;
        int d;
        int words;
        int perms;
        int fin;
        int hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    vec_t        vecs[11];
    exp_t        sb[$];
    int          checks;
    int          fails;
    logic [31:0] salt;
    logic [7:0]  epoch;

    int          rel, words, fin_cnt, fin_rel, rd_cnt, vcnt, preq_cnt, perms, pwait;
    int          hold_word, hold_cnt, timing_on;
    logic        prev_stall, prev_last;
    logic [31:0] prev_dt;

    function automatic logic [31:0] mk(input int a, input int e);
        logic [7:0] a8;
        logic [7:0] e8;
        a8 = a[7:0];
        e8 = e[7:0];
        return {8'h5A, e8, 8'h00, a8} ^ salt;
    endfunction

    function automatic int rate_of(input int m);
        case (m)
            0: return 36;
            1: return 34;
            2: return 26;
            3: return 18;
            4: return 42;
            5: return 34;
            default: return 1;
        endcase
    endfunction

    // State buffer model: data valid one cycle after st_rd, tagged with the permutation epoch.
    always @(posedge clk) begin
        if (start && !busy)
            epoch <= 8'd0;
        else if (perm_req && perm_done)
            epoch <= epoch + 8'd1;
        st_data <= st_rd ? mk(int'(st_addr), int'(epoch)) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        rel++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            perm_done  = 1'b0;
            return;
        end
        if (perm_req && !perm_done) begin
            pwait++;
            if (pwait == 24) begin
                perm_done = 1'b1;
                pwait     = 0;
                perms++;
            end
        end else begin
            perm_done = 1'b0;
        end
        if (o_valid && words == hold_word && hold_cnt < 5) begin
            o_ready = 1'b0;
            hold_cnt++;
        end else begin
            o_ready = 1'b1;
        end
        if (prev_stall) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", dt_o_hash, prev_dt);
            chk("stall_last", o_last, prev_last);
            chk("stall_st_rd", st_rd, 0);
        end
        if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("word_data", dt_o_hash, e.data);
                chk("word_last", o_last, e.last);
            end
            if (timing_on != 0 && perms == 0)
                chk("word_cycle", rel, 3 + 3 * words);
            words++;
        end
        prev_stall = o_valid && !o_ready;
        prev_dt    = dt_o_hash;
        prev_last  = o_last;
        if (finish_hash) begin
            fin_cnt++;
            fin_rel = rel;
        end
        if (st_rd)    rd_cnt++;
        if (o_valid)  vcnt++;
        if (perm_req) preq_cnt++;
    endtask

    task automatic start_txn(input int m, input int dd, input int nexp, input int hw);
        exp_t e;
        int   r;
        step();
        salt       = $urandom;
        sb.delete();
        words      = 0;
        fin_cnt    = 0;
        fin_rel    = -1;
        rd_cnt     = 0;
        vcnt       = 0;
        preq_cnt   = 0;
        perms      = 0;
        pwait      = 0;
        hold_word  = hw;
        hold_cnt   = 0;
        timing_on  = (hw < 0) ? 1 : 0;
        prev_stall = 1'b0;
        rel        = 0;
        r          = rate_of(m);
        for (int i = 0; i < nexp; i++) begin
            e.data = mk(i % r, i / r);
            e.last = (i == nexp - 1);
            sb.push_back(e);
        end
        cmode = m[2:0];
        d     = dd[10:0];
        start = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (fin_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (fin_cnt == 0)
            chk("finish_timeout", 0, 1);
        step();
        step();
    endtask

    task automatic run_vec(input vec_t v);
        start_txn(v.cmode, v.d, v.words, v.hold);
        wait_done(400);
        chk("word_count", words, v.words);
        chk("sb_left", sb.size(), 0);
        chk("perm_count", perms, v.perms);
        chk("finish_count", fin_cnt, 1);
        chk("read_count", rd_cnt, v.words);
        if (v.fin >= 0)
            chk("finish_cycle", fin_rel, v.fin);
        if (v.words == 0)
            chk("valid_cycles", vcnt, 0);
        if (v.perms == 0)
            chk("perm_req_cycles", preq_cnt, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        salt      = 32'd0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cmode     = 3'd0;
        d         = 11'd0;
        o_ready   = 1'b1;
        perm_done = 1'b0;
        hold_word = -1;
        rel       = 0;

        vecs[0]  = '{cmode: 1, d: 0,    words: 8,  perms: 0, fin: 25,  hold: -1};
        vecs[1]  = '{cmode: 0, d: 0,    words: 7,  perms: 0, fin: 22,  hold: -1};
        vecs[2]  = '{cmode: 2, d: 0,    words: 12, perms: 0, fin: 37,  hold: -1};
        vecs[3]  = '{cmode: 3, d: 0,    words: 16, perms: 0, fin: 54,  hold: 3};
        vecs[4]  = '{cmode: 4, d: 2016, words: 63, perms: 1, fin: 214, hold: -1};
        vecs[5]  = '{cmode: 5, d: 31,   words: 0,  perms: 0, fin: 1,   hold: -1};
        vecs[6]  = '{cmode: 7, d: 0,    words: 0,  perms: 0, fin: 1,   hold: -1};
        vecs[7]  = '{cmode: 5, d: 2047, words: 63, perms: 1, fin: 214, hold: -1};
        vecs[8]  = '{cmode: 4, d: 100,  words: 3,  perms: 0, fin: 10,  hold: -1};
        vecs[9]  = '{cmode: 6, d: 2047, words: 0,  perms: 0, fin: 1,   hold: -1};
        vecs[10] = '{cmode: 4, d: 1344, words: 42, perms: 0, fin: 127, hold: -1};

        repeat (3) @(negedge clk);
        chk("rst_st_rd", st_rd, 0);
        chk("rst_st_addr", st_addr, 0);
        chk("rst_perm_req", perm_req, 0);
        chk("rst_dt_o_hash", dt_o_hash, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_finish_hash", finish_hash, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i]);

        // Second start while busy, with a different mode, must be ignored.
        start_txn(1, 0, 8, -1);
        repeat (4) step();
        chk("busy_mid", busy, 1);
        cmode = 3'd7;
        start = 1'b1;
        wait_done(100);
        chk("restart_words", words, 8);
        chk("restart_finish_count", fin_cnt, 1);
        chk("restart_finish_cycle", fin_rel, 25);

        // Reset during a stalled OUT of SHA3-384 word 5.
        start_txn(2, 0, 12, 5);
        begin
            int n;
            n = 0;
            while (!(words == 5 && o_valid && !o_ready) && n < 100) begin
                step();
                n++;
            end
            chk("reach_word5", words, 5);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_st_rd", st_rd, 0);
        chk("mid_rst_st_addr", st_addr, 0);
        chk("mid_rst_perm_req", perm_req, 0);
        chk("mid_rst_dt_o_hash", dt_o_hash, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_last", o_last, 0);
        chk("mid_rst_finish_hash", finish_hash, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst_n     = 1'b1;
        hold_word = -1;
        repeat (3) step();
        chk("aborted_finish", fin_cnt, 0);
        run_vec('{cmode: 0, d: 0, words: 7, perms: 0, fin: 22, hold: -1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
